// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and default operand width.
package serial_subtractor_pkg;
    localparam int DEFAULT_WIDTH = 3;
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit a - b - bin with borrow out.
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first a - b producing difference, borrow and overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d;
    logic             diff, bnext;
    logic [WIDTH-1:0] r_shift;

    full_subtractor u_fs (
        .ai  (a_q[0]),
        .bi  (b_q[0]),
        .bin (brw_q),
        .diff(diff),
        .bout(bnext)
    );

    assign r_shift = {diff, r_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = SUB;
                a_d     = a;
                b_d     = b;
                r_d     = '0;
                cnt_d   = '0;
                brw_d   = 1'b0;
            end
        end else if (state_q == SUB) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = r_shift;
            brw_d = bnext;
            cnt_d = cnt_q + 1'b1;
            // On the MSB bit a_q[0]/b_q[0] hold the operand sign bits.
            if (cnt_q == LAST) begin
                state_d = DONE;
                y_d     = r_shift;
                bout_d  = bnext;
                ovf_d   = (a_q[0] != b_q[0]) & (diff != a_q[0]);
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y    = y_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == SUB);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors checked against an arithmetic reference model every cycle.
module tb_serial_subtractor;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] y;
    logic         bout, ovf, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .y    (y),
        .bout (bout),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..W processing, W+1 result pulse.
    int m_phase = 0;
    int m_a = 0, m_b = 0;
    int m_y = 0, m_bout = 0, m_ovf = 0;

    function automatic int to_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    always @(negedge rst_n) begin
        m_phase = 0;
        m_y = 0;
        m_bout = 0;
        m_ovf = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_phase == 0) begin
                if (start) begin
                    m_a = int'(a);
                    m_b = int'(b);
                    m_phase = 1;
                end
            end else if (m_phase <= W) begin
                m_phase++;
                if (m_phase == W + 1) begin
                    int sd;
                    sd = to_signed(m_a) - to_signed(m_b);
                    m_y = (m_a - m_b + (1 << W)) % (1 << W);
                    m_bout = (m_a < m_b) ? 1 : 0;
                    m_ovf = (sd > (1 << (W - 1)) - 1 || sd < -(1 << (W - 1))) ? 1 : 0;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), (m_phase >= 1 && m_phase <= W) ? 1 : 0);
        chk("done", int'(done), (m_phase == W + 1) ? 1 : 0);
        chk("y", int'(y), m_y);
        chk("bout", int'(bout), m_bout);
        chk("ovf", int'(ovf), m_ovf);
        chk("busy_and_done", int'(busy & done), 0);
    end

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int ey, input int eb, input int eo);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        else begin
            chk("lit_y", int'(y), ey);
            chk("lit_bout", int'(bout), eb);
            chk("lit_ovf", int'(ovf), eo);
        end
    endtask

    initial begin
        int dones;
        #12;
        chk("rst_y", int'(y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b011, 3'b001, 2, 0, 0);
        run_op(3'b001, 3'b011, 6, 1, 0);
        run_op(3'b000, 3'b000, 0, 0, 0);
        run_op(3'b100, 3'b001, 3, 0, 1);
        run_op(3'b011, 3'b110, 5, 1, 1);

        @(negedge clk);
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
            a = W'($urandom);
            b = W'($urandom);
        end
        chk("b2b_done_count", dones, 4);
        start = 1'b0;
        repeat (6) @(negedge clk);

        start = 1'b1;
        a = 3'b101;
        b = 3'b010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_bout", int'(bout), 0);
        chk("arst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("no_done_after_reset", dones, 0);

        run_op(3'b111, 3'b100, 3, 0, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
